// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants, derived totals and the coordinate type
// shared by the VGA timing generator and its consumers.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // True when val lies in the closed interval [lo, hi].
  function automatic logic in_window(input coord_t val, input int lo, input int hi);
    int v_s;
    v_s = int'(val);
    return (v_s >= lo) && (v_s <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// System-clock divider producing a one-clk pixel enable every CLK_DIV clks.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divider_r;

  // Free-running divider, wraps after CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divider_r <= {DIV_W{1'b0}};
    end else if (divider_r == DIV_LAST) begin
      divider_r <= {DIV_W{1'b0}};
    end else begin
      divider_r <= divider_r + 1'b1;
    end
  end

  // Gating with reset keeps the enable low in reset even when CLK_DIV is 1.
  assign p_tick = ~reset & (divider_r == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: scan counters, registered sync pulses, visible-area flag
// and line/frame strobes, advanced by the pixel enable from pixel_tick_gen.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK    = vga_timing_pkg::H_BACK,
  parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK    = vga_timing_pkg::V_BACK,
  parameter int   CLK_DIV   = 2,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_PERIOD = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_PERIOD = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = COORD_W'(H_PERIOD - 1);
  localparam coord_t V_LAST = COORD_W'(V_PERIOD - 1);
  localparam coord_t H_VIS  = COORD_W'(H_DISPLAY);
  localparam coord_t V_VIS  = COORD_W'(V_DISPLAY);

  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic   p_tick_s;
  coord_t h_count_r;
  coord_t v_count_r;
  coord_t h_next_s;
  coord_t v_next_s;
  logic   hsync_next_s;
  logic   vsync_next_s;
  logic   hsync_r;
  logic   vsync_r;
  logic   line_tick_s;
  logic   frame_tick_s;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick_gen (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick_s)
  );

  // Next raster position: horizontal steps on every pixel, vertical on line wrap.
  always_comb begin
    h_next_s = h_count_r;
    v_next_s = v_count_r;
    if (p_tick_s) begin
      if (h_count_r == H_LAST) begin
        h_next_s = {COORD_W{1'b0}};
        if (v_count_r == V_LAST) begin
          v_next_s = {COORD_W{1'b0}};
        end else begin
          v_next_s = v_count_r + 1'b1;
        end
      end else begin
        h_next_s = h_count_r + 1'b1;
        v_next_s = v_count_r;
      end
    end else begin
      h_next_s = h_count_r;
      v_next_s = v_count_r;
    end
  end

  // Sync levels decoded from the next position so they line up with the counters.
  always_comb begin
    hsync_next_s = ~SYNC_POL;
    vsync_next_s = ~SYNC_POL;
    if (in_window(h_next_s, HS_START, HS_END)) begin
      hsync_next_s = SYNC_POL;
    end else begin
      hsync_next_s = ~SYNC_POL;
    end
    if (in_window(v_next_s, VS_START, VS_END)) begin
      vsync_next_s = SYNC_POL;
    end else begin
      vsync_next_s = ~SYNC_POL;
    end
  end

  // Scan counters and registered sync outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_count_r <= {COORD_W{1'b0}};
      v_count_r <= {COORD_W{1'b0}};
      hsync_r   <= ~SYNC_POL;
      vsync_r   <= ~SYNC_POL;
    end else begin
      h_count_r <= h_next_s;
      v_count_r <= v_next_s;
      hsync_r   <= hsync_next_s;
      vsync_r   <= vsync_next_s;
    end
  end

  assign line_tick_s  = p_tick_s & (h_count_r == H_LAST);
  assign frame_tick_s = line_tick_s & (v_count_r == V_LAST);

  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign video_on   = (h_count_r < H_VIS) && (v_count_r < V_VIS);
  assign p_tick     = p_tick_s;
  assign pixel_x    = h_count_r;
  assign pixel_y    = v_count_r;
  assign line_tick  = line_tick_s;
  assign frame_tick = frame_tick_s;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-width lines with a shortened vertical
// raster (8 lines) so whole frames fit in a short run.
module tb_vga_timing_gen;

  // Shortened vertical timing: 4 visible, 1 front, 2 sync (y=5..6), 1 back.
  localparam int TB_V_DISPLAY = 4;
  localparam int TB_V_FRONT   = 1;
  localparam int TB_V_SYNC    = 2;
  localparam int TB_V_BACK    = 1;
  // Frame = 800 pixels * 8 lines * 2 clks = 12800 clks.
  localparam int FRAME_CLKS   = 12800;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_tick;
  logic       frame_tick;

  int tests_run;
  int tests_failed;

  vga_timing_gen #(
    .H_DISPLAY(640),
    .H_FRONT  (16),
    .H_SYNC   (96),
    .H_BACK   (48),
    .V_DISPLAY(TB_V_DISPLAY),
    .V_FRONT  (TB_V_FRONT),
    .V_SYNC   (TB_V_SYNC),
    .V_BACK   (TB_V_BACK),
    .CLK_DIV  (2),
    .SYNC_POL (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hsync     (hsync),
    .vsync     (vsync),
    .video_on  (video_on),
    .p_tick    (p_tick),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .line_tick (line_tick),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Assert reset at a negedge, hold for 'hold' negedges, release at a negedge.
  task automatic pulse_reset(input int hold);
    @(negedge clk);
    reset = 1'b1;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance to the last clk of pixel (x,y); ok=0 if the budget runs out.
  task automatic wait_xy(input int x, input int y, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(pixel_x) == x && int'(pixel_y) == y && p_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (37) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({pixel_x, pixel_y} !== 20'd0 || hsync !== 1'b1 || vsync !== 1'b1 || video_on !== 1'b1 ||
        p_tick !== 1'b0 || line_tick !== 1'b0 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async: x=%0d y=%0d hs=%b vs=%b von=%b pt=%b lt=%b ft=%b, want 0 0 1 1 1 0 0 0",
               pixel_x, pixel_y, hsync, vsync, video_on, p_tick, line_tick, frame_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (p_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_tick: p_tick=%b want 0", p_tick);
    end
    @(negedge clk);
    tests_run++;
    if (p_tick !== 1'b1 || pixel_x !== 10'd0) begin
      tests_failed++;
      $display("FAIL first_tick: p_tick=%b x=%0d want 1 0", p_tick, pixel_x);
    end
    @(negedge clk);
    tests_run++;
    if (p_tick !== 1'b0 || pixel_x !== 10'd1) begin
      tests_failed++;
      $display("FAIL second_pixel: p_tick=%b x=%0d want 0 1", p_tick, pixel_x);
    end
  endtask

  task automatic test_tick_cadence;
    int   ticks;
    int   doubles;
    logic prev;
    ticks = 0;
    doubles = 0;
    prev = 1'b0;
    pulse_reset(2);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (p_tick === 1'b1) ticks++;
      if (p_tick === 1'b1 && prev === 1'b1) doubles++;
      prev = p_tick;
    end
    tests_run++;
    if (ticks != 50) begin
      tests_failed++;
      $display("FAIL tick_count: got %0d want 50", ticks);
    end
    tests_run++;
    if (doubles != 0) begin
      tests_failed++;
      $display("FAIL tick_adjacent: got %0d back-to-back ticks want 0", doubles);
    end
    tests_run++;
    if (pixel_x !== 10'd50) begin
      tests_failed++;
      $display("FAIL tick_pixel_x: got %0d want 50", pixel_x);
    end
  endtask

  task automatic test_line_wrap;
    bit ok;
    pulse_reset(2);
    wait_xy(799, 5, 20000, ok);
    tests_run++;
    if (!ok || line_tick !== 1'b1 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL line_tick: reached=%0d lt=%b ft=%b want 1 1 0", ok, line_tick, frame_tick);
    end
    @(negedge clk);
    tests_run++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd6 || line_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL line_wrap: x=%0d y=%0d lt=%b want 0 6 0", pixel_x, pixel_y, line_tick);
    end
  endtask

  task automatic test_hsync_window;
    int low_clks;
    int low_pix;
    int x_min;
    int x_max;
    int von_err;
    logic von_exp;
    low_clks = 0;
    low_pix = 0;
    x_min = 1023;
    x_max = -1;
    von_err = 0;
    pulse_reset(2);
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      von_exp = (int'(pixel_x) < 640) && (int'(pixel_y) < TB_V_DISPLAY);
      if (video_on !== von_exp) von_err++;
      if (hsync === 1'b0) begin
        low_clks++;
        if (p_tick === 1'b1) low_pix++;
        if (int'(pixel_x) < x_min) x_min = int'(pixel_x);
        if (int'(pixel_x) > x_max) x_max = int'(pixel_x);
      end
    end
    tests_run++;
    if (low_clks != 192 || low_pix != 96) begin
      tests_failed++;
      $display("FAIL hsync_width: clks=%0d pixels=%0d want 192 96", low_clks, low_pix);
    end
    tests_run++;
    if (x_min != 656 || x_max != 751) begin
      tests_failed++;
      $display("FAIL hsync_range: x=%0d..%0d want 656..751", x_min, x_max);
    end
    tests_run++;
    if (von_err != 0) begin
      tests_failed++;
      $display("FAIL video_on: %0d wrong samples want 0", von_err);
    end
  endtask

  task automatic test_frame;
    int first;
    int second;
    int vs_pix;
    int y_min;
    int y_max;
    first = 0;
    second = 0;
    vs_pix = 0;
    y_min = 1023;
    y_max = -1;
    pulse_reset(2);
    for (int k = 1; k <= 3 * FRAME_CLKS; k++) begin
      @(negedge clk);
      if (first == 0 && vsync === 1'b0) begin
        if (p_tick === 1'b1) vs_pix++;
        if (int'(pixel_y) < y_min) y_min = int'(pixel_y);
        if (int'(pixel_y) > y_max) y_max = int'(pixel_y);
      end
      if (frame_tick === 1'b1) begin
        if (first == 0) begin
          first = k;
          tests_run++;
          if (pixel_x !== 10'd799 || pixel_y !== 10'd7) begin
            tests_failed++;
            $display("FAIL frame_tick_pos: x=%0d y=%0d want 799 7", pixel_x, pixel_y);
          end
        end else begin
          second = k;
          break;
        end
      end
    end
    // Last pixel of the first frame carries the enable on clk 12799 after release.
    tests_run++;
    if (first != FRAME_CLKS - 1) begin
      tests_failed++;
      $display("FAIL frame_first: clk %0d want %0d", first, FRAME_CLKS - 1);
    end
    tests_run++;
    if (second - first != FRAME_CLKS) begin
      tests_failed++;
      $display("FAIL frame_period: %0d clks want %0d", second - first, FRAME_CLKS);
    end
    tests_run++;
    if (vs_pix != 1600 || y_min != 5 || y_max != 6) begin
      tests_failed++;
      $display("FAIL vsync_window: pixels=%0d y=%0d..%0d want 1600 5..6", vs_pix, y_min, y_max);
    end
    @(negedge clk);
    tests_run++;
    if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || frame_tick !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_wrap: x=%0d y=%0d ft=%b want 0 0 0", pixel_x, pixel_y, frame_tick);
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int held_err;
    int first;
    held_err = 0;
    first = 0;
    pulse_reset(2);
    wait_xy(300, 3, 20000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL midframe_reach: reached=%0d want 1", ok);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pixel_x !== 10'd0 || pixel_y !== 10'd0 || p_tick !== 1'b0) held_err++;
    end
    reset = 1'b0;
    tests_run++;
    if (held_err != 0) begin
      tests_failed++;
      $display("FAIL midframe_hold: %0d samples off (0,0) want 0", held_err);
    end
    for (int k = 1; k <= 2 * FRAME_CLKS; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        first = k;
        break;
      end
    end
    tests_run++;
    if (first != FRAME_CLKS - 1) begin
      tests_failed++;
      $display("FAIL midframe_frame: clk %0d want %0d", first, FRAME_CLKS - 1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_tick_cadence();
    test_line_wrap();
    test_hsync_window();
    test_frame();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
